// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader and the decode stage that consumes its output.
package instr_loader_pkg;

  localparam int unsigned INSTR_W       = 17;
  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_CSUM = 3'd1;
  localparam logic [2:0] ERR_LEN  = 3'd2;
  localparam logic [2:0] ERR_FMT  = 3'd3;
  localparam logic [2:0] ERR_TMO  = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_B0,
    S_B1,
    S_B2,
    S_CSUM,
    S_DONE,
    S_ERR
  } ldr_state_e;

endpackage

// File: rtl/instr_loader_timeout.sv
// Inter-byte watchdog: counts cycles while enabled, clears on each accepted byte.
module ldr_timeout #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // An accepted byte on the final cycle wins over expiry.
  assign expired = en && !clr && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || !en || expired) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/instr_loader.sv
// Parses framed UART bytes into 17-bit instruction words, writes them to IM and
// releases the CPU from reset only after the whole image passes its checksum.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned IM_ADDR_W   = 12,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           in_data,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic                 reload,
  output logic                 im_we,
  output logic [IM_ADDR_W-1:0] im_addr,
  output logic [INSTR_W-1:0]   im_wdata,
  output logic                 cpu_rst_n,
  output logic                 done,
  output logic [2:0]           err_code,
  output logic [IM_ADDR_W:0]   words_loaded
);

  localparam logic [16:0] MAX_WORDS = 17'(2 ** IM_ADDR_W);

  ldr_state_e           state_q, state_d;
  logic                 rdy_q;
  logic [15:0]          len_q, len_d;
  logic [7:0]           xor_q, xor_d;
  logic                 b0_q, b0_d;
  logic [7:0]           b1_q, b1_d;
  logic [IM_ADDR_W:0]   words_q, words_d;
  logic [2:0]           err_q, err_d;
  logic                 we_q, we_d;
  logic [IM_ADDR_W-1:0] addr_q, addr_d;
  logic [INSTR_W-1:0]   wdata_q, wdata_d;
  logic                 done_q, done_d;
  logic                 cpu_rst_n_q, cpu_rst_n_d;

  logic        accept;
  logic        tmo_en, tmo_exp;
  logic [15:0] n_words, next_cnt;

  assign in_rdy   = rdy_q & ~reload;
  assign accept   = in_vld & in_rdy;
  assign tmo_en   = state_q inside {S_LEN_HI, S_LEN_LO, S_B0, S_B1, S_B2, S_CSUM};
  assign n_words  = {len_q[15:8], in_data};
  assign next_cnt = 16'(words_q) + 16'd1;

  ldr_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (tmo_en),
    .clr    (accept),
    .expired(tmo_exp)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    xor_d   = xor_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    words_d = words_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      case (state_q)
        S_IDLE: if (in_data == SYNC_BYTE) begin
          state_d = S_LEN_HI;
          xor_d   = '0;
          words_d = '0;
        end
        S_LEN_HI: begin
          len_d   = {in_data, 8'h00};
          xor_d   = xor_q ^ in_data;
          state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d = n_words;
          xor_d = xor_q ^ in_data;
          if ({1'b0, n_words} > MAX_WORDS) begin
            state_d = S_ERR;
            err_d   = ERR_LEN;
          end else if (n_words == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_B0;
          end
        end
        S_B0: begin
          xor_d = xor_q ^ in_data;
          if (in_data[7:1] != 7'd0) begin
            state_d = S_ERR;
            err_d   = ERR_FMT;
          end else begin
            b0_d    = in_data[0];
            state_d = S_B1;
          end
        end
        S_B1: begin
          b1_d    = in_data;
          xor_d   = xor_q ^ in_data;
          state_d = S_B2;
        end
        S_B2: begin
          xor_d   = xor_q ^ in_data;
          we_d    = 1'b1;
          addr_d  = words_q[IM_ADDR_W-1:0];
          wdata_d = {b0_q, b1_q, in_data};
          words_d = words_q + (IM_ADDR_W+1)'(1);
          state_d = (next_cnt == len_q) ? S_CSUM : S_B0;
        end
        S_CSUM: begin
          if (in_data == xor_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
            err_d   = ERR_CSUM;
          end
        end
        default: ;
      endcase
    end
    if (tmo_exp) begin
      state_d = S_ERR;
      err_d   = ERR_TMO;
    end
    // reload outranks everything, including a write being issued this cycle.
    if (reload) begin
      state_d = S_IDLE;
      err_d   = ERR_NONE;
      words_d = '0;
      we_d    = 1'b0;
    end
    done_d      = (state_d == S_DONE);
    cpu_rst_n_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rdy_q       <= 1'b0;
      len_q       <= '0;
      xor_q       <= '0;
      b0_q        <= 1'b0;
      b1_q        <= '0;
      words_q     <= '0;
      err_q       <= ERR_NONE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= 1'b1;
      len_q       <= len_d;
      xor_q       <= xor_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      words_q     <= words_d;
      err_q       <= err_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  assign im_we        = we_q;
  assign im_addr      = addr_q;
  assign im_wdata     = wdata_q;
  assign done         = done_q;
  assign cpu_rst_n    = cpu_rst_n_q;
  assign err_code     = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with a frame-parsing reference model checked every cycle.
module tb_instr_loader;

  localparam int unsigned AW  = 4;
  localparam int unsigned TMO = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_vld = 1'b0;
  logic          reload = 1'b0;
  logic          in_rdy, im_we, cpu_rst_n, done;
  logic [AW-1:0] im_addr;
  logic [16:0]   im_wdata;
  logic [2:0]    err_code;
  logic [AW:0]   words_loaded;

  int errors = 0;
  int checks = 0;

  instr_loader #(.IM_ADDR_W(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_vld      (in_vld),
    .in_rdy      (in_rdy),
    .reload      (reload),
    .im_we       (im_we),
    .im_addr     (im_addr),
    .im_wdata    (im_wdata),
    .cpu_rst_n   (cpu_rst_n),
    .done        (done),
    .err_code    (err_code),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: re-parses the bytes accepted after SYNC from scratch.
  logic [7:0]  fb[$];
  bit          m_rdy = 0, m_act = 0, m_tmo = 0, acc;
  int          m_idle = 0;
  bit          e_we = 0, e_done = 0;
  int          e_addr = 0, e_words = 0, e_err = 0;
  logic [16:0] e_wdata = '0;
  int          nw0, nw1, st, ec;
  logic [16:0] lw;

  // st: 0 frame incomplete, 1 verified, 2 error (ec holds the code)
  function automatic void parse(input logic [7:0] q[$], output int nw, output int s,
                                output int e, output logic [16:0] last);
    int n, p;
    logic [7:0] b, x;
    nw = 0; s = 0; e = 0; last = '0;
    if (q.size() < 2) return;
    n = int'({q[0], q[1]});
    if (n > (1 << AW)) begin s = 2; e = 2; return; end
    for (int w = 0; w < n; w++) begin
      p = 2 + 3 * w;
      if (q.size() <= p) return;
      b = q[p];
      if (b[7:1] != 7'd0) begin s = 2; e = 3; return; end
      if (q.size() < p + 3) return;
      last = {b[0], q[p+1], q[p+2]};
      nw = w + 1;
    end
    p = 2 + 3 * n;
    if (q.size() <= p) return;
    x = '0;
    for (int i = 0; i < p; i++) x ^= q[i];
    if (x == q[p]) s = 1;
    else begin s = 2; e = 1; end
  endfunction

  always @(posedge clk) begin
    e_we = 0;
    if (!rst_n) begin
      m_rdy = 0; m_act = 0; m_tmo = 0; m_idle = 0; fb.delete();
      e_addr = 0; e_wdata = '0;
    end else begin
      acc = in_vld && m_rdy && !reload;
      if (reload) begin
        m_act = 0; m_tmo = 0; m_idle = 0; fb.delete();
      end else if (!m_act) begin
        if (acc && in_data == 8'hA5) begin
          m_act = 1; m_idle = 0; fb.delete();
        end
      end else begin
        parse(fb, nw0, st, ec, lw);
        if (st == 0 && !m_tmo) begin
          if (acc) begin
            fb.push_back(in_data);
            m_idle = 0;
            parse(fb, nw1, st, ec, lw);
            if (nw1 > nw0) begin e_we = 1; e_addr = nw0; e_wdata = lw; end
          end else begin
            m_idle++;
            if (m_idle >= TMO) m_tmo = 1;
          end
        end
      end
      m_rdy = 1;
    end
    parse(fb, nw0, st, ec, lw);
    e_words = m_act ? nw0 : 0;
    e_done  = m_act && st == 1;
    e_err   = m_tmo ? 4 : ((m_act && st == 2) ? ec : 0);
  end

  logic [AW-1:0] wl_addr[$];
  logic [16:0]   wl_data[$];

  always @(negedge clk) begin
    check("in_rdy", 32'(in_rdy), 32'(m_rdy && !reload));
    check("im_we", 32'(im_we), 32'(e_we));
    if (e_we || !rst_n) begin
      check("im_addr", 32'(im_addr), e_addr);
      check("im_wdata", 32'(im_wdata), 32'(e_wdata));
    end
    check("done", 32'(done), 32'(e_done));
    check("cpu_rst_n", 32'(cpu_rst_n), 32'(e_done));
    check("err_code", 32'(err_code), e_err);
    check("words_loaded", 32'(words_loaded), e_words);
    if (im_we) begin
      wl_addr.push_back(im_addr);
      wl_data.push_back(im_wdata);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b);
    in_data = b; in_vld = 1'b1;
    tick(1);
    in_vld = 1'b0;
  endtask

  task automatic send_bytes(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) send(v[8*(n-1-i) +: 8]);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick(1);
    reload = 1'b0;
  endtask

  task automatic clear_log();
    wl_addr.delete();
    wl_data.delete();
  endtask

  logic [7:0] x, b1v, b2v;

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // nominal two-word image
    clear_log();
    send_bytes(128'hA5_00_02_01_23_45_00_BE_EF_34, 10);
    check("nom_done_next", 32'(done), 32'd1);
    check("nom_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    check("nom_nwrites", wl_data.size(), 32'd2);
    if (wl_data.size() == 2) begin
      check("nom_addr0", 32'(wl_addr[0]), 32'd0);
      check("nom_data0", 32'(wl_data[0]), 32'h12345);
      check("nom_addr1", 32'(wl_addr[1]), 32'd1);
      check("nom_data1", 32'(wl_data[1]), 32'h0BEEF);
    end
    check("nom_words", 32'(words_loaded), 32'd2);
    tick(3);
    pulse_reload();
    check("reload_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("reload_done", 32'(done), 32'd0);
    check("reload_words", 32'(words_loaded), 32'd0);

    // bad checksum
    clear_log();
    send_bytes(128'hA5_00_02_01_23_45_00_BE_EF_35, 10);
    tick(2);
    check("csum_err", 32'(err_code), 32'd1);
    check("csum_nwrites", wl_data.size(), 32'd2);
    check("csum_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    pulse_reload();
    check("csum_reload_err", 32'(err_code), 32'd0);

    // format error: no write, error right after the bad B0
    clear_log();
    send_bytes(128'hA5_00_01_02, 4);
    check("fmt_err", 32'(err_code), 32'd3);
    send_bytes(128'h23_45_A5, 3);
    tick(2);
    check("fmt_sticky", 32'(err_code), 32'd3);
    check("fmt_nwrites", wl_data.size(), 32'd0);
    pulse_reload();

    // empty image
    clear_log();
    send_bytes(128'hA5_00_00_00, 4);
    check("empty_done", 32'(done), 32'd1);
    check("empty_nwrites", wl_data.size(), 32'd0);
    pulse_reload();

    // length limit: 17 words exceeds 2^4
    send_bytes(128'hA5_00_11, 3);
    check("len_err", 32'(err_code), 32'd2);
    pulse_reload();

    // exactly 16 words with idle gaps between bytes
    clear_log();
    send(8'hA5); tick($urandom_range(0, 20));
    send(8'h00); tick($urandom_range(0, 20));
    send(8'h10); tick($urandom_range(0, 20));
    x = 8'h10;
    for (int w = 0; w < 16; w++) begin
      b1v = 8'(w * 7);
      b2v = 8'hFF - 8'(w);
      send(8'(w & 1)); tick($urandom_range(0, 20));
      send(b1v);       tick($urandom_range(0, 20));
      send(b2v);       tick($urandom_range(0, 20));
      x = x ^ 8'(w & 1) ^ b1v ^ b2v;
    end
    send(x);
    check("max_done", 32'(done), 32'd1);
    check("max_words", 32'(words_loaded), 32'd16);
    check("max_nwrites", wl_data.size(), 32'd16);
    if (wl_data.size() == 16) check("max_last", 32'(wl_data[15]), 32'h169F0);
    pulse_reload();

    // junk then timeout
    send_bytes(128'h00_FF_A5_00_01, 5);
    tick(TMO - 1);
    check("tmo_before", 32'(err_code), 32'd0);
    tick(1);
    check("tmo_at", 32'(err_code), 32'd4);
    check("tmo_done", 32'(done), 32'd0);
    pulse_reload();

    // reload after the first B1 abandons the frame
    clear_log();
    send_bytes(128'hA5_00_02_01_23, 5);
    pulse_reload();
    send_bytes(128'h45_00_BE_EF_34, 5);
    check("mid_nwrites", wl_data.size(), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    send_bytes(128'hA5_00_02_01_23_45_00_BE_EF_34, 10);
    check("mid_new_done", 32'(done), 32'd1);
    pulse_reload();

    // reload coincident with accepted bytes: both dropped
    clear_log();
    send_bytes(128'hA5_00_01_01_23, 5);
    in_data = 8'h45; in_vld = 1'b1; reload = 1'b1;
    tick(1);
    in_data = 8'hA5;
    tick(1);
    in_vld = 1'b0; reload = 1'b0;
    send_bytes(128'h00_00_00, 3);
    tick(2);
    check("coin_nwrites", wl_data.size(), 32'd0);
    check("coin_done", 32'(done), 32'd0);
    check("coin_words", 32'(words_loaded), 32'd0);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
